msrv32_dmem_access_unit: RTL

Data-memory access stage directly upstream of the load unit. It accepts one load/store request at a time from the execute stage, checks alignment and drives a req/ack data-memory bus with word-aligned address, byte mask and lane-replicated write data. It captures read data and the load attributes into registers that feed the load unit. It reports misalignment and bus-timeout errors and signals busy for pipeline stall.

---
 rtl/msrv32_dmem_access_unit.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/msrv32_dmem_access_unit.sv
// rtl/msrv32_dmem_access_unit.sv - data-memory access stage: alignment check, req/ack bus master, load-unit capture
module msrv32_dmem_access_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        req_valid_in,
    output logic        req_ready_out,
    input  logic        req_is_store_in,
    input  logic [31:0] req_addr_in,
    input  logic [31:0] req_wdata_in,
    input  logic [1:0]  req_size_in,
    input  logic        req_unsigned_in,
    input  logic        flush_in,
    output logic        dm_req_out,
    output logic        dm_we_out,
    output logic [31:0] dm_addr_out,
    output logic [31:0] dm_wdata_out,
    output logic [3:0]  dm_wr_mask_out,
    input  logic        dm_ack_in,
    input  logic [31:0] dm_rdata_in,
    output logic [31:0] ms_riscv32_mp_dmdata_out,
    output logic [1:0]  iadder_out_1_to_0_out,
    output logic [1:0]  load_size_out,
    output logic        load_unsigned_out,
    output logic        rsp_valid_out,
    output logic        rsp_is_load_out,
    output logic        misaligned_out,
    output logic        bus_err_out,
    output logic        busy_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             kill_q;
    logic             is_store_q;

    logic             misaligned_w;
    logic [3:0]       mask_w;
    logic [31:0]      wdata_w;

    assign req_ready_out = (state_q == S_IDLE);
    assign busy_out      = (state_q != S_IDLE);

    assign misaligned_w = ((req_size_in == 2'b01) && req_addr_in[0]) ||
                          (req_size_in[1] && (req_addr_in[1:0] != 2'b00));

    // Store data is replicated across all lanes so the mask alone picks the bytes
    always_comb begin
        mask_w  = 4'b1111;
        wdata_w = req_wdata_in;
        case (req_size_in)
            2'b00: begin
                mask_w  = 4'b0001 << req_addr_in[1:0];
                wdata_w = {4{req_wdata_in[7:0]}};
            end
            2'b01: begin
                mask_w  = req_addr_in[1] ? 4'b1100 : 4'b0011;
                wdata_w = {2{req_wdata_in[15:0]}};
            end
            default: begin
                mask_w  = 4'b1111;
                wdata_w = req_wdata_in;
            end
        endcase
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            state_q                  <= S_IDLE;
            cnt_q                    <= '0;
            kill_q                   <= 1'b0;
            is_store_q               <= 1'b0;
            dm_req_out               <= 1'b0;
            dm_we_out                <= 1'b0;
            dm_addr_out              <= '0;
            dm_wdata_out             <= '0;
            dm_wr_mask_out           <= '0;
            ms_riscv32_mp_dmdata_out <= '0;
            iadder_out_1_to_0_out    <= '0;
            load_size_out            <= '0;
            load_unsigned_out        <= 1'b0;
            rsp_valid_out            <= 1'b0;
            rsp_is_load_out          <= 1'b0;
            misaligned_out           <= 1'b0;
            bus_err_out              <= 1'b0;
        end else begin
            rsp_valid_out   <= 1'b0;
            rsp_is_load_out <= 1'b0;
            misaligned_out  <= 1'b0;
            bus_err_out     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid_in && !flush_in) begin
                        if (misaligned_w) begin
                            misaligned_out <= 1'b1;
                        end else begin
                            state_q               <= S_REQ;
                            cnt_q                 <= '0;
                            kill_q                <= 1'b0;
                            is_store_q            <= req_is_store_in;
                            dm_req_out            <= 1'b1;
                            dm_we_out             <= req_is_store_in;
                            dm_addr_out           <= {req_addr_in[31:2], 2'b00};
                            dm_wr_mask_out        <= req_is_store_in ? mask_w : 4'b0000;
                            dm_wdata_out          <= req_is_store_in ? wdata_w : 32'd0;
                            iadder_out_1_to_0_out <= req_addr_in[1:0];
                            load_size_out         <= req_size_in;
                            load_unsigned_out     <= req_unsigned_in;
                        end
                    end
                end
                S_REQ: begin
                    if (flush_in) begin
                        kill_q <= 1'b1;
                    end
                    // Ack is checked before the timeout so a last-cycle ack still completes
                    if (dm_ack_in) begin
                        if (!is_store_q) begin
                            ms_riscv32_mp_dmdata_out <= dm_rdata_in;
                        end
                        dm_req_out      <= 1'b0;
                        dm_we_out       <= 1'b0;
                        state_q         <= S_RESP;
                        rsp_valid_out   <= !(kill_q || flush_in);
                        rsp_is_load_out <= !is_store_q && !(kill_q || flush_in);
                    end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                        dm_req_out  <= 1'b0;
                        dm_we_out   <= 1'b0;
                        bus_err_out <= 1'b1;
                        state_q     <= S_IDLE;
                        cnt_q       <= '0;
                        kill_q      <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    kill_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
